// File: rtl/key_sched_if.sv
// key_sched_if: bundles the key-schedule handshake, S-box loop and round-key output bus
interface key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic [127:0] round_key;
    logic         round_key_valid;
    logic [3:0]   round_idx;
    logic [3:0]   kx_round;
    logic [1:0]   kx_index;
    logic         busy;
    logic         done;
    modport master (
        output start, key_in, sbox_out,
        input  sbox_in, round_key, round_key_valid, round_idx, kx_round, kx_index, busy, done
    );
    modport slave (
        input  start, key_in, sbox_out,
        output sbox_in, round_key, round_key_valid, round_idx, kx_round, kx_index, busy, done
    );
endinterface

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: AES-128 key expansion sequencer, one 32-bit word per clock, in-place over w0..w3
module key_sched_ctrl (
    input logic        clk,
    input logic        rst_n,
    key_sched_if.slave bus
);
    typedef enum logic {IDLE, EXPAND} state_t;
    state_t      state_q, state_d;
    logic [31:0] w_q [4];
    logic [31:0] w_d [4];
    logic [3:0]  r_q, r_d, idx_q, idx_d;
    logic [1:0]  i_q, i_d;
    logic        valid_q, valid_d, done_q, done_d, armed_q;
    logic [7:0]  rcon;
    logic [31:0] w_new;
    assign rcon  = r_q == 4'd8 ? 8'h1b : r_q == 4'd9 ? 8'h36 : 8'(8'h01 << r_q[2:0]);
    assign w_new = i_q == 2'd0 ? w_q[0] ^ bus.sbox_out ^ {rcon, 24'h0}
                               : w_q[i_q] ^ w_q[i_q - 2'd1];
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        r_d     = r_q;
        i_d     = i_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            // armed_q masks a start that lands on the edge releasing reset
            if (bus.start && armed_q) begin
                w_d[0]  = bus.key_in[127:96];
                w_d[1]  = bus.key_in[95:64];
                w_d[2]  = bus.key_in[63:32];
                w_d[3]  = bus.key_in[31:0];
                r_d     = 4'd0;
                i_d     = 2'd0;
                idx_d   = 4'd0;
                valid_d = 1'b1;
                state_d = EXPAND;
            end
        end else begin
            w_d[i_q] = w_new;
            i_d      = i_q + 2'd1;
            if (i_q == 2'd3) begin
                valid_d = 1'b1;
                idx_d   = r_q + 4'd1;
                r_d     = r_q == 4'd9 ? 4'd0 : r_q + 4'd1;
                done_d  = r_q == 4'd9;
                state_d = r_q == 4'd9 ? IDLE : EXPAND;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '{default: 32'h0};
            r_q     <= 4'd0;
            i_q     <= 2'd0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            r_q     <= r_d;
            i_q     <= i_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            armed_q <= 1'b1;
        end
    end
    assign bus.sbox_in         = {w_q[3][23:0], w_q[3][31:24]};
    assign bus.round_key       = {w_q[0], w_q[1], w_q[2], w_q[3]};
    assign bus.round_key_valid = valid_q;
    assign bus.round_idx       = idx_q;
    assign bus.kx_round        = r_q;
    assign bus.kx_index        = i_q;
    assign bus.busy            = state_q == EXPAND;
    assign bus.done            = done_q;
endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequencer for the AES-128 key expansion. It accepts a 128-bit cipher key and produces all eleven round keys, one 32-bit word per clock. Each round key is presented as a registered 128-bit value with a one-cycle valid pulse. It drives the key-XOR stage's control encoding (round number, word index) and uses an external 4-byte S-box lookup for SubWord.

## Interface
- No parameters; fixed to AES-128 (Nk=4, Nr=10).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request expansion; sampled only in IDLE
- key_in  in  128  cipher key; key_in[127:120] is byte 0; sampled with start
- sbox_out  in  32  combinational S-box result of sbox_in, bytewise
- sbox_in  out  32  RotWord(w3) = {w3[23:0], w3[31:24]}, driven combinationally from the w3 register
- round_key  out  128  {w0,w1,w2,w3}; meaningful only while round_key_valid=1
- round_key_valid  out  1  one-cycle pulse per completed round key
- round_idx  out  4  index (0..10) of round_key
- kx_round  out  4  key-XOR round number (0..9), equal to the internal round counter r
- kx_index  out  2  key-XOR word index (0..3), equal to the internal word counter i
- busy  out  1  high while in EXPAND
- done  out  1  one-cycle pulse coincident with round 10 valid

## Operation
- FSM states: IDLE and EXPAND. Counters: r[3:0] (0..9) and i[1:0].
- IDLE, start=1:
  - Load w0..w3 from key_in.
  - Set r=0, i=0. Next cycle: round_key_valid=1, round_idx=0, state=EXPAND.
- EXPAND, every cycle, overwrite w[i] in place:
  - i=0: w0 ← w0 ^ sbox_out ^ {rcon(r), 24'h0}.
  - i=1..3: w[i] ← w[i] ^ w[i-1], where w[i-1] is the value already updated this round.
- rcon(r) for r=0..9: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- i increments each cycle and wraps 3→0.
- On the i=3 write:
  - r increments.
  - Next cycle: round_key_valid=1, round_idx=r+1.
- On the r=9, i=3 write:
  - Next cycle: round_key_valid=1, round_idx=10, done=1, state=IDLE.
  - r and i return to 0.
- start while busy is ignored and is not queued.
- key_in is ignored except in the start-accept cycle.
- All XOR is bytewise modulo 2; no carries; widths are fixed and no truncation occurs.

## Timing
- Cycle numbering: the start edge is edge 0. Outputs seen in cycle n were updated at edge n-1.
- Round key k is valid in cycle 1+4k: round 0 in cycle 1, round 1 in cycle 5, round 10 in cycle 41.
- busy=1 in cycles 1..40 and 0 in cycle 41.
- A start asserted in cycle 41 is accepted; the next round 0 appears in cycle 42.
- Between valid pulses round_key holds a partially updated mix; consumers sample only on round_key_valid.
- sbox_in/sbox_out loop is a same-cycle combinational path through the external S-box; no extra latency allowed.
- Reset values (async, immediate on rst_n=0):
  - state=IDLE, r=0, i=0.
  - w0..w3=0, so round_key=0 and sbox_in=0.
  - round_key_valid=0, round_idx=0, busy=0, done=0, kx_round=0, kx_index=0.
- Reset mid-expansion aborts with no further valid pulses. The first start after rst_n rises restarts from round 0.
- round_idx holds its last value between pulses.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle:
  - cycle 1: valid, round_idx=0, round_key = the key.
  - cycle 1: sbox_in=cf4f3c09.
  - cycle 5: round_key=a0fafe1788542cb123a339392a6c7605.
  - cycle 41: round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, done=1.
- Pulse counts for the same run:
  - exactly 11 valid pulses, with round_idx 0..10 in order.
  - busy high for exactly 40 cycles.
  - kx_index cycles 0,1,2,3 and kx_round steps 0..9.
- start held high continuously:
  - expansions run back-to-back.
  - second round 0 appears in cycle 42.
  - starts during busy cause no disturbance.
- Key 00…00:
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset pulsed at cycle 20:
  - all outputs are 0 immediately.
  - no valid pulse until a new start.
  - the new run reproduces the FIPS-197 sequence exactly.
- start asserted on the same edge that rst_n deasserts: ignored; block stays IDLE.
